// File: rtl/serial_max_search.sv
// Serial max search: consumes one operand per cycle and reports the group maximum and word count.
// Define SEARCH_INDEX_EN to also track and output the position of the maximum (out_idx).
module serial_max_search #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
`ifdef SEARCH_INDEX_EN
  output logic [IW-1:0]    out_idx,
`endif
  output logic [IW:0]      out_cnt
);

  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
`ifdef SEARCH_INDEX_EN
  logic [IW-1:0]    idx_q, idx_d;
`endif

  // in_ready depends only on registered state, so there is no in_valid -> in_ready path.
  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign out_max   = max_q;
  assign out_cnt   = cnt_q;
`ifdef SEARCH_INDEX_EN
  assign out_idx   = idx_q;
`endif

  always_comb begin
    // NOTE: combinational blocks use blocking assignments, and every output gets a default
    // first so no path through the case statement leaves a signal unassigned (no latches).
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
`ifdef SEARCH_INDEX_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          max_d   = in_data;
          cnt_d   = CW'(1);
`ifdef SEARCH_INDEX_EN
          idx_d   = '0;
`endif
          state_d = in_last ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          // Strict compare keeps the earliest position on ties.
          if (in_data > max_q) begin
            max_d = in_data;
`ifdef SEARCH_INDEX_EN
            idx_d = cnt_q[IW-1:0];
`endif
          end
          cnt_d = cnt_q + CW'(1);
          if (in_last || (cnt_q == CW'(DEPTH - 1))) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous on assert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      cnt_q   <= '0;
`ifdef SEARCH_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
`ifdef SEARCH_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_max_search.sv
// Self-checking bench for serial_max_search: directed vector table, hand-written
// corner sequences and randomized groups checked against a behavioural max model.
module tb_serial_max_search;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IW:0]      out_cnt;
`ifdef SEARCH_INDEX_EN
  logic [IW-1:0]    out_idx;
`endif

  int checks = 0;
  int errors = 0;

  serial_max_search #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
`ifdef SEARCH_INDEX_EN
    .out_idx  (out_idx),
`endif
    .out_cnt  (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][WIDTH-1:0] w;
    int                    n;
    bit                    last;
    logic [WIDTH-1:0]      exp_max;
    int                    exp_idx;
    int                    exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] w3, input int n, input bit last,
                              input logic [7:0] m, input int idx, input int cnt);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.n = n; v.last = last; v.exp_max = m; v.exp_idx = idx; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic push_word(input logic [WIDTH-1:0] d, input bit last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic take_result(input string name, input logic [WIDTH-1:0] em, input int ei,
                             input int ec, input int hold);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 1);
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    check({name, "_max"}, 32'(out_max), 32'(em));
    check({name, "_cnt"}, 32'(out_cnt), 32'(ec));
`ifdef SEARCH_INDEX_EN
    check({name, "_idx"}, 32'(out_idx), 32'(ei));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release"}, 32'(out_valid), 0);
  endtask

  // Reference: group max first, then the first position holding that value.
  function automatic void model(input logic [3:0][WIDTH-1:0] w, input int n,
                                output logic [WIDTH-1:0] m, output int idx);
    int best = 0;
    for (int i = 0; i < n; i++) if (int'(w[i]) > best) best = int'(w[i]);
    m   = WIDTH'(best);
    idx = -1;
    for (int i = 0; i < n; i++) if (idx < 0 && int'(w[i]) == best) idx = i;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [9];

  initial begin
    logic [3:0][WIDTH-1:0] rw;
    logic [WIDTH-1:0]      rm;
    int                    ri;
    int                    rn;
    bit                    lst;

    vecs[0] = mk(8'h12, 8'h7F, 8'h30, 8'h05, 4, 1'b0, 8'h7F, 1, 4);
    vecs[1] = mk(8'h40, 8'h40, 8'h40, 8'h3F, 4, 1'b0, 8'h40, 0, 4);
    vecs[2] = mk(8'hA5, 8'h00, 8'h00, 8'h00, 1, 1'b1, 8'hA5, 0, 1);
    vecs[3] = mk(8'h00, 8'h00, 8'h00, 8'h00, 4, 1'b0, 8'h00, 0, 4);
    vecs[4] = mk(8'h01, 8'hFF, 8'hFF, 8'h02, 4, 1'b1, 8'hFF, 1, 4);
    vecs[5] = mk(8'h10, 8'h20, 8'h30, 8'h00, 3, 1'b1, 8'h30, 2, 3);
    vecs[6] = mk(8'h80, 8'h7F, 8'h00, 8'h00, 2, 1'b1, 8'h80, 0, 2);
    vecs[7] = mk(8'h05, 8'h05, 8'h09, 8'h09, 4, 1'b0, 8'h09, 2, 4);
    vecs[8] = mk(8'hFE, 8'hFF, 8'h00, 8'hFF, 4, 1'b0, 8'hFF, 1, 4);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_max", 32'(out_max), 0);
    check("rst_out_cnt", 32'(out_cnt), 0);
`ifdef SEARCH_INDEX_EN
    check("rst_out_idx", 32'(out_idx), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; out_valid must be up one cycle after the closing accept.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        push_word(vecs[v].w[i], vecs[v].last && (i == vecs[v].n - 1));
      check($sformatf("vec%0d_latency", v), 32'(out_valid), 1);
      take_result($sformatf("vec%0d", v), vecs[v].exp_max, vecs[v].exp_idx, vecs[v].exp_cnt, v % 3);
    end

    // Result held for 5 cycles while the next word is offered: stalled, not dropped.
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b1);
    in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 0);
      check($sformatf("stall%0d_max", c), 32'(out_max), 32'h22);
      check($sformatf("stall%0d_cnt", c), 32'(out_cnt), 2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 32'(out_valid), 0);
    check("stall_release_ready", 32'(in_ready), 1);
    push_word(8'h33, 1'b1);
    out_ready = 1'b0;
    take_result("stalled_word", 8'h33, 0, 1, 0);

    // Reset mid-group discards the partial group.
    push_word(8'hF0, 1'b0);
    push_word(8'hE0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_cnt", 32'(out_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_word(WIDTH'(i + 1), 1'b0);
    take_result("after_midrst", 8'h04, 3, 4, 0);

    // Reset while holding a result.
    push_word(8'hA5, 1'b1);
    check("holdrst_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("holdrst_out_valid", 32'(out_valid), 0);
    check("holdrst_max", 32'(out_max), 0);
    check("holdrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized groups with random in_last, bubbles and out_ready activity.
    for (int g = 0; g < 300; g++) begin
      rn = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++)
        rw[i] = $urandom_range(0, 1) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 3) * 85);
      model(rw, rn, rm, ri);
      for (int i = 0; i < rn; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        lst = (i == rn - 1) ? ((rn < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        out_ready = (i == rn - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        push_word(rw[i], lst);
      end
      check($sformatf("rnd%0d_latency", g), 32'(out_valid), 1);
      take_result($sformatf("rnd%0d", g), rm, ri, rn, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
